// File: rtl/lc3_pkg.sv
// -----------------------------------------------------------------------------
// lc3_pkg
//   Shared definitions for the LC-3 control slice: control-state encoding,
//   opcode values (IR[15:12]) and the datapath mux/ALU select encodings.
// -----------------------------------------------------------------------------
package lc3_pkg;

  typedef enum logic [4:0] {
    S_HALTED   = 5'd0,
    S_FETCH1   = 5'd1,
    S_FETCH2   = 5'd2,
    S_FETCH3   = 5'd3,
    S_DECODE   = 5'd4,
    S_ADD      = 5'd5,
    S_AND      = 5'd6,
    S_NOT      = 5'd7,
    S_BR       = 5'd8,
    S_BR_TAKEN = 5'd9,
    S_JMP      = 5'd10,
    S_JSR1     = 5'd11,
    S_JSR2     = 5'd12,
    S_LDR1     = 5'd13,
    S_LDR2     = 5'd14,
    S_LDR3     = 5'd15,
    S_STR1     = 5'd16,
    S_STR2     = 5'd17,
    S_STR3     = 5'd18,
    S_PAUSE1   = 5'd19,
    S_PAUSE2   = 5'd20
  } state_t;

  // Opcodes as they appear in IR[15:12]
  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  // PC input mux
  localparam logic [1:0] PCMUX_PC1   = 2'd0;
  localparam logic [1:0] PCMUX_BUS   = 2'd1;
  localparam logic [1:0] PCMUX_ADDER = 2'd2;

  // Address adder operand selects
  localparam logic       ADDR1_PC    = 1'b0;
  localparam logic       ADDR1_SR1   = 1'b1;
  localparam logic [1:0] ADDR2_ZERO  = 2'd0;
  localparam logic [1:0] ADDR2_OFF6  = 2'd1;
  localparam logic [1:0] ADDR2_OFF9  = 2'd2;
  localparam logic [1:0] ADDR2_OFF11 = 2'd3;

  // ALU function
  localparam logic [1:0] ALUK_ADD  = 2'd0;
  localparam logic [1:0] ALUK_AND  = 2'd1;
  localparam logic [1:0] ALUK_NOT  = 2'd2;
  localparam logic [1:0] ALUK_PASS = 2'd3;

  // States that stall on the memory handshake and are covered by the timeout
  function automatic logic is_mem_wait(input state_t s);
    return (s == S_FETCH2) || (s == S_LDR2) || (s == S_STR3);
  endfunction

endpackage

// File: rtl/lc3_mem_wait.sv
// -----------------------------------------------------------------------------
// lc3_mem_wait
//   Counts consecutive cycles spent in a memory-wait state without Mem_ready
//   and flags a timeout on the MEM_TIMEOUT-th such cycle.
//   Ports:
//     Clk, Reset_n  clock / async active-low reset
//     in_wait       FSM is currently in a memory-wait state
//     mem_ready     memory completes its access this cycle
//     timeout       combinational: this cycle is the last allowed one and
//                   memory still is not ready
// -----------------------------------------------------------------------------
module lc3_mem_wait #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic in_wait,
  input  logic mem_ready,
  output logic timeout
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;

  // Wait states are never back-to-back, so clearing whenever the FSM is not
  // stalling gives a fresh count on every entry.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wait_cnt <= '0;
    end else if (in_wait && !mem_ready) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      wait_cnt <= wait_cnt + CW'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // A ready arriving on the final cycle suppresses the timeout.
  assign timeout = in_wait && !mem_ready && (wait_cnt == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/lc3_control_fsm.sv
// -----------------------------------------------------------------------------
// lc3_control_fsm
//   Moore control FSM sequencing LC-3 fetch / decode / execute.
//   Inputs : Clk, Reset_n (async, active-low), Run, Continue, Opcode[3:0],
//            IR_5, IR_11, BEN (registered branch enable), Mem_ready
//   Outputs: register loads LD_MAR/MDR/IR/BEN/CC/REG/PC/LED,
//            bus gates GatePC/GateMDR/GateALU/GateMARMUX (at most one high),
//            mux selects PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX,
//            ALUK, memory strobes Mem_OE/Mem_WE, sticky Mem_err.
// -----------------------------------------------------------------------------
module lc3_control_fsm
  import lc3_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  input  logic       Mem_ready,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic       Mem_err
);

  state_t state, state_next;
  logic   mem_err_q;
  logic   mem_timeout;

  lc3_mem_wait #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .in_wait   (is_mem_wait(state)),
    .mem_ready (Mem_ready),
    .timeout   (mem_timeout)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path through the block leaves
    // state_next unassigned, which would infer a latch.
    state_next = state;
    unique case (state)
      S_HALTED:   if (Run) state_next = S_FETCH1;
      S_FETCH1:   state_next = S_FETCH2;
      S_FETCH2:   if (Mem_ready) state_next = S_FETCH3;
      S_FETCH3:   state_next = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_ADD:   state_next = S_ADD;
          OP_AND:   state_next = S_AND;
          OP_NOT:   state_next = S_NOT;
          OP_BR:    state_next = S_BR;
          OP_JMP:   state_next = S_JMP;
          OP_JSR:   state_next = S_JSR1;
          OP_LDR:   state_next = S_LDR1;
          OP_STR:   state_next = S_STR1;
          OP_PAUSE: state_next = S_PAUSE1;
          default:  state_next = S_FETCH1;  // unimplemented opcodes act as NOP
        endcase
      end
      S_ADD, S_AND, S_NOT: state_next = S_FETCH1;
      // BEN was loaded on the DECODE edge, so it is valid here.
      S_BR:       state_next = BEN ? S_BR_TAKEN : S_FETCH1;
      S_BR_TAKEN: state_next = S_FETCH1;
      S_JMP:      state_next = S_FETCH1;
      S_JSR1:     state_next = S_JSR2;
      S_JSR2:     state_next = S_FETCH1;
      S_LDR1:     state_next = S_LDR2;
      S_LDR2:     if (Mem_ready) state_next = S_LDR3;
      S_LDR3:     state_next = S_FETCH1;
      S_STR1:     state_next = S_STR2;
      S_STR2:     state_next = S_STR3;
      S_STR3:     if (Mem_ready) state_next = S_FETCH1;
      S_PAUSE1:   if (Continue) state_next = S_PAUSE2;
      S_PAUSE2:   if (!Continue) state_next = S_FETCH1;
      default:    state_next = S_HALTED;
    endcase
    // A stalled memory access aborts whatever the state table chose.
    if (mem_timeout) state_next = S_HALTED;
  end

  // ---------------------------------------------------------------------------
  // Output decode (Moore; IR_5/IR_11 only steer selects that are IR fields)
  // ---------------------------------------------------------------------------
  always_comb begin
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = PCMUX_PC1;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = ADDR1_PC;
    ADDR2MUX   = ADDR2_ZERO;
    ALUK       = ALUK_ADD;
    Mem_OE     = 1'b0;
    Mem_WE     = 1'b0;
    unique case (state)
      S_FETCH1: begin
        GatePC = 1'b1;
        LD_MAR = 1'b1;
        PCMUX  = PCMUX_PC1;
        LD_PC  = 1'b1;
      end
      S_FETCH2, S_LDR2: begin
        Mem_OE = 1'b1;
        LD_MDR = 1'b1;
      end
      S_FETCH3: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
      end
      S_DECODE: LD_BEN = 1'b1;
      S_ADD, S_AND, S_NOT: begin
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        SR2MUX  = IR_5;
        ALUK    = (state == S_ADD) ? ALUK_ADD :
                  (state == S_AND) ? ALUK_AND : ALUK_NOT;
      end
      S_BR_TAKEN: begin
        ADDR1MUX = ADDR1_PC;
        ADDR2MUX = ADDR2_OFF9;
        PCMUX    = PCMUX_ADDER;
        LD_PC    = 1'b1;
      end
      S_JMP: begin
        ADDR1MUX = ADDR1_SR1;
        ADDR2MUX = ADDR2_ZERO;
        PCMUX    = PCMUX_ADDER;
        LD_PC    = 1'b1;
      end
      S_JSR1: begin
        GatePC = 1'b1;
        DRMUX  = 1'b1;
        LD_REG = 1'b1;
      end
      S_JSR2: begin
        // JSRR reaches SR1 through the adder with a zero offset.
        ADDR1MUX = IR_11 ? ADDR1_PC : ADDR1_SR1;
        ADDR2MUX = IR_11 ? ADDR2_OFF11 : ADDR2_ZERO;
        PCMUX    = PCMUX_ADDER;
        LD_PC    = 1'b1;
      end
      S_LDR1, S_STR1: begin
        ADDR1MUX   = ADDR1_SR1;
        ADDR2MUX   = ADDR2_OFF6;
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
      end
      S_LDR3: begin
        GateMDR = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S_STR2: begin
        // Source register is in IR[11:9]; ALU passes it through to MDR.
        SR1MUX  = 1'b1;
        ALUK    = ALUK_PASS;
        GateALU = 1'b1;
        LD_MDR  = 1'b1;
      end
      S_STR3:   Mem_WE = 1'b1;
      S_PAUSE1: LD_LED = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and sticky error
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= S_HALTED;
      mem_err_q <= 1'b0;
    end else begin
      state <= state_next;
      if (mem_timeout) mem_err_q <= 1'b1;
    end
  end

  assign Mem_err = mem_err_q;

endmodule

// File: tb/tb_lc3_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_lc3_control_fsm
//   Instruction-level reference model: each instruction is expanded into the
//   micro-operations it needs (PC->MAR, memory read, MDR->IR, ALU op, ...),
//   one expected control word per cycle, pushed into a scoreboard queue as the
//   stimulus for that cycle is issued. A monitor pops and compares on the
//   falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lc3_control_fsm;

  localparam int MEM_TIMEOUT = 15;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic       drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux, aluk;
    logic       mem_oe, mem_we, mem_err;
  } ctrl_t;

  logic       Clk, Reset_n, Run, Continue, IR_5, IR_11, BEN, Mem_ready;
  logic [3:0] Opcode;
  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_OE, Mem_WE, Mem_err;

  lc3_control_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Continue(Continue),
    .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN), .Mem_ready(Mem_ready),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
    .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
    .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .Mem_err(Mem_err)
  );

  ctrl_t act;
  assign act = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                GatePC, GateMDR, GateALU, GateMARMUX, PCMUX,
                DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
                Mem_OE, Mem_WE, Mem_err};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int    checks = 0;
  int    errors = 0;
  ctrl_t exp_q[$];
  string lab_q[$];

  // Model state: halted flag and sticky error
  bit m_halted = 1'b1;
  bit m_err    = 1'b0;

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      ctrl_t e;
      string l;
      e = exp_q.pop_front();
      l = lab_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s @%0t: got %h expected %h", l, $time, act, e);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Micro-operation control words
  // ---------------------------------------------------------------------------
  function automatic ctrl_t w_idle();
    ctrl_t w = '0;
    return w;
  endfunction

  function automatic ctrl_t w_pc_to_mar();   // MAR<-PC, PC<-PC+1
    ctrl_t w = '0;
    w.gate_pc = 1'b1; w.ld_mar = 1'b1; w.ld_pc = 1'b1; w.pcmux = 2'd0;
    return w;
  endfunction

  function automatic ctrl_t w_mem_read();
    ctrl_t w = '0;
    w.mem_oe = 1'b1; w.ld_mdr = 1'b1;
    return w;
  endfunction

  function automatic ctrl_t w_mdr_to_ir();
    ctrl_t w = '0;
    w.gate_mdr = 1'b1; w.ld_ir = 1'b1;
    return w;
  endfunction

  function automatic ctrl_t w_decode();
    ctrl_t w = '0;
    w.ld_ben = 1'b1;
    return w;
  endfunction

  function automatic ctrl_t w_alu(input logic [1:0] fn, input logic imm);
    ctrl_t w = '0;
    w.gate_alu = 1'b1; w.ld_reg = 1'b1; w.ld_cc = 1'b1; w.sr2mux = imm; w.aluk = fn;
    return w;
  endfunction

  function automatic ctrl_t w_pc_adder(input logic base_sr1, input logic [1:0] off);
    ctrl_t w = '0;
    w.addr1mux = base_sr1; w.addr2mux = off; w.pcmux = 2'd2; w.ld_pc = 1'b1;
    return w;
  endfunction

  function automatic ctrl_t w_save_r7();
    ctrl_t w = '0;
    w.gate_pc = 1'b1; w.drmux = 1'b1; w.ld_reg = 1'b1;
    return w;
  endfunction

  function automatic ctrl_t w_ea_to_mar();   // MAR<-SR1+off6
    ctrl_t w = '0;
    w.addr1mux = 1'b1; w.addr2mux = 2'd1; w.gate_marmux = 1'b1; w.ld_mar = 1'b1;
    return w;
  endfunction

  function automatic ctrl_t w_mdr_to_reg();
    ctrl_t w = '0;
    w.gate_mdr = 1'b1; w.ld_reg = 1'b1; w.ld_cc = 1'b1;
    return w;
  endfunction

  function automatic ctrl_t w_sr_to_mdr();   // MDR<-R[IR[11:9]] via ALU pass
    ctrl_t w = '0;
    w.sr1mux = 1'b1; w.aluk = 2'd3; w.gate_alu = 1'b1; w.ld_mdr = 1'b1;
    return w;
  endfunction

  function automatic ctrl_t w_mem_write();
    ctrl_t w = '0;
    w.mem_we = 1'b1;
    return w;
  endfunction

  function automatic ctrl_t w_led();
    ctrl_t w = '0;
    w.ld_led = 1'b1;
    return w;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus tasks (called just after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic expect_word(input ctrl_t w, input string lab);
    w.mem_err = m_err;
    exp_q.push_back(w);
    lab_q.push_back(lab);
  endtask

  // One running cycle; Run is randomised since it must be ignored here.
  task automatic step(input ctrl_t w, input string lab, input logic rdy, input logic cont);
    expect_word(w, lab);
    Mem_ready = rdy;
    Continue  = cont;
    Run       = rbit();
    @(posedge Clk); #1;
  endtask

  task automatic halted_cycle(input logic run);
    expect_word(w_idle(), "halted");
    Run       = run;
    Mem_ready = rbit();
    Continue  = rbit();
    @(posedge Clk); #1;
    Run = 1'b0;
  endtask

  // Memory access stalled for 'waits' cycles; too long a stall halts with error.
  task automatic mem_access(input ctrl_t w, input string lab, input int waits, output bit ok);
    int n;
    n = (waits < MEM_TIMEOUT) ? waits : MEM_TIMEOUT;
    for (int i = 0; i < n; i++) step(w, lab, 1'b0, rbit());
    if (waits >= MEM_TIMEOUT) begin
      m_err    = 1'b1;
      m_halted = 1'b1;
      ok       = 1'b0;
    end else begin
      step(w, lab, 1'b1, rbit());
      ok = 1'b1;
    end
  endtask

  task automatic fetch_decode(input logic [3:0] op, input logic ir5, input logic ir11,
                              input logic ben, input int fw, output bit ok);
    if (m_halted) begin
      halted_cycle(1'b1);
      m_halted = 1'b0;
    end
    Opcode = op; IR_5 = ir5; IR_11 = ir11; BEN = ben;
    step(w_pc_to_mar(), "fetch1", rbit(), rbit());
    mem_access(w_mem_read(), "fetch2", fw, ok);
    if (!ok) return;
    step(w_mdr_to_ir(), "fetch3", rbit(), rbit());
    step(w_decode(), "decode", rbit(), rbit());
  endtask

  task automatic run_instr(input logic [3:0] op, input logic ir5, input logic ir11,
                           input logic ben, input int fw, input int dw,
                           input int c1, input int c2);
    bit ok;
    fetch_decode(op, ir5, ir11, ben, fw, ok);
    if (!ok) return;
    case (op)
      4'b0001: step(w_alu(2'd0, ir5), "add", rbit(), rbit());
      4'b0101: step(w_alu(2'd1, ir5), "and", rbit(), rbit());
      4'b1001: step(w_alu(2'd2, ir5), "not", rbit(), rbit());
      4'b0000: begin
        step(w_idle(), "br", rbit(), rbit());
        if (ben) step(w_pc_adder(1'b0, 2'd2), "br_taken", rbit(), rbit());
      end
      4'b1100: step(w_pc_adder(1'b1, 2'd0), "jmp", rbit(), rbit());
      4'b0100: begin
        step(w_save_r7(), "jsr1", rbit(), rbit());
        step(ir11 ? w_pc_adder(1'b0, 2'd3) : w_pc_adder(1'b1, 2'd0), "jsr2", rbit(), rbit());
      end
      4'b0110: begin
        step(w_ea_to_mar(), "ldr1", rbit(), rbit());
        mem_access(w_mem_read(), "ldr2", dw, ok);
        if (ok) step(w_mdr_to_reg(), "ldr3", rbit(), rbit());
      end
      4'b0111: begin
        step(w_ea_to_mar(), "str1", rbit(), rbit());
        step(w_sr_to_mdr(), "str2", rbit(), rbit());
        mem_access(w_mem_write(), "str3", dw, ok);
      end
      4'b1101: begin
        for (int i = 0; i < c1; i++) step(w_led(), "pause1", rbit(), 1'b0);
        step(w_led(), "pause1", rbit(), 1'b1);
        for (int i = 0; i < c2; i++) step(w_idle(), "pause2", rbit(), 1'b1);
        step(w_idle(), "pause2", rbit(), 1'b0);
      end
      default: ;  // NOP: straight back to fetch
    endcase
  endtask

  task automatic rand_instr();
    logic [3:0] op;
    int fw, dw;
    op = 4'($urandom_range(0, 15));
    fw = ($urandom_range(0, 29) == 0) ? MEM_TIMEOUT : $urandom_range(0, 3);
    dw = ($urandom_range(0, 14) == 0) ? MEM_TIMEOUT : $urandom_range(0, 3);
    run_instr(op, rbit(), rbit(), rbit(), fw, dw, $urandom_range(0, 3), $urandom_range(0, 3));
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    bit ok;
    Reset_n = 1'b0; Run = 1'b0; Continue = 1'b0; Opcode = 4'h0;
    IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0; Mem_ready = 1'b0;

    // Outputs all zero while held in reset
    expect_word(w_idle(), "in_reset");
    expect_word(w_idle(), "in_reset");
    repeat (2) @(negedge Clk);
    #2 Reset_n = 1'b1;
    @(posedge Clk); #1;

    // HALTED ignores everything but Run
    halted_cycle(1'b0);
    halted_cycle(1'b0);

    // Directed instructions
    run_instr(4'b0001, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);   // ADD imm
    run_instr(4'b0000, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0);   // BR taken
    run_instr(4'b0000, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);   // BR not taken
    run_instr(4'b0110, 1'b0, 1'b0, 1'b0, 0, 3, 0, 0);   // LDR, 3 wait cycles
    run_instr(4'b1101, 1'b0, 1'b0, 1'b0, 0, 0, 2, 1);   // PAUSE
    run_instr(4'b0100, 1'b0, 1'b1, 1'b0, 1, 0, 0, 0);   // JSR
    run_instr(4'b0100, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);   // JSRR
    run_instr(4'b1100, 1'b0, 1'b0, 1'b0, 2, 0, 0, 0);   // JMP
    run_instr(4'b0111, 1'b0, 1'b0, 1'b0, 0, 1, 0, 0);   // STR
    run_instr(4'b1001, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);   // NOT
    run_instr(4'b0101, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);   // AND reg
    run_instr(4'b1111, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);   // NOP

    // Timeout boundary: last-cycle ready still completes, one more stalls out
    run_instr(4'b0001, 1'b0, 1'b0, 1'b0, MEM_TIMEOUT - 1, 0, 0, 0);
    run_instr(4'b0001, 1'b0, 1'b0, 1'b0, MEM_TIMEOUT, 0, 0, 0);
    halted_cycle(1'b0);
    halted_cycle(1'b0);
    run_instr(4'b0110, 1'b0, 1'b0, 1'b0, 0, MEM_TIMEOUT - 1, 0, 0);
    run_instr(4'b0111, 1'b0, 1'b0, 1'b0, 0, MEM_TIMEOUT, 0, 0);
    halted_cycle(1'b0);

    // Randomised instruction stream
    for (int i = 0; i < 80; i++) rand_instr();

    // Park in PAUSE1, then pull reset mid-cycle
    fetch_decode(4'b1101, 1'b0, 1'b0, 1'b0, 0, ok);
    if (ok) begin
      for (int i = 0; i < 3; i++) step(w_led(), "pause1", rbit(), 1'b0);
      #2 Reset_n = 1'b0;
      #1;
      checks++;
      if (act !== ctrl_t'(0)) begin
        errors++;
        $display("FAIL async_reset: got %h expected %h", act, ctrl_t'(0));
      end
      #20 Reset_n = 1'b1;
    end

    // Scoreboard must have drained
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge Clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
